bht_update_ctrl: RTL

Controller that sequences all writes into the branch history table (BHT) of 2-bit saturating counters. After reset it runs an initialisation sweep that writes every entry to weakly-taken, replacing any reliance on simulation-only initial values. It then queues resolved-branch outcomes from the MEM stage in a small FIFO and applies each one as a read-modify-write through the BHT's shared read port and its single write port. The decode-stage lookup always has priority on the read port.

---
 rtl/bht_update_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - BHT write sequencer: init sweep, then FIFO-queued read-modify-write of 2-bit counters
module bht_update_ctrl #(
  parameter int         IDX_W      = 4,
  parameter int         DEPTH      = 4,
  parameter logic [1:0] INIT_STATE = 2'b10,
  localparam int        CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_addr,
  output logic             resolve_ready,
  input  logic             lookup_active,
  output logic             bht_rsel,
  output logic [IDX_W-1:0] bht_ridx,
  input  logic [1:0]       bht_rdata,
  output logic             bht_we,
  output logic [IDX_W-1:0] bht_widx,
  output logic [1:0]       bht_wdata,
  output logic             init_busy,
  output logic             overflow,
  output logic [CNT_W-1:0] pending
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0]   INIT_END = {1'b1, {IDX_W{1'b0}}};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W:0]     r_init_ptr;
  logic [IDX_W:0]     w_init_ptr_nxt;
  logic               r_we;
  logic [IDX_W-1:0]   r_widx;
  logic [1:0]         r_wdata;
  logic               w_we_nxt;
  logic [IDX_W-1:0]   w_widx_nxt;
  logic [1:0]         w_wdata_nxt;
  logic               r_overflow;

  // Each FIFO entry is {taken, index}; the rest of the PC is not needed.
  logic [IDX_W:0]     r_fifo [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;
  logic               w_head_taken;
  logic [IDX_W-1:0]   w_head_idx;
  logic               w_unused_addr;

  function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      sat2 = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      sat2 = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
  endfunction

  assign w_unused_addr = ^resolve_addr[31:IDX_W];
  assign w_head_taken  = r_fifo[r_head][IDX_W];
  assign w_head_idx    = r_fifo[r_head][IDX_W-1:0];

  assign init_busy     = (r_state == ST_INIT);
  // Full check ignores a same-cycle pop to keep ready off the read-port path.
  assign resolve_ready = !init_busy && (r_count != FULL_CNT);
  assign w_push        = resolve_valid && resolve_ready;

  assign bht_we    = r_we;
  assign bht_widx  = r_widx;
  assign bht_wdata = r_wdata;
  assign overflow  = r_overflow;
  assign pending   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
      r_we       <= 1'b0;
      r_widx     <= '0;
      r_wdata    <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
      r_we       <= w_we_nxt;
      r_widx     <= w_widx_nxt;
      r_wdata    <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_we_nxt       = 1'b0;
    w_widx_nxt     = r_widx;
    w_wdata_nxt    = r_wdata;
    w_pop          = 1'b0;
    bht_rsel       = 1'b0;
    bht_ridx       = '0;
    case (r_state)
      ST_INIT: begin
        if (r_init_ptr == INIT_END) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_nxt       = 1'b1;
          w_widx_nxt     = r_init_ptr[IDX_W-1:0];
          w_wdata_nxt    = INIT_STATE;
          w_init_ptr_nxt = r_init_ptr + (IDX_W+1)'(1);
        end
      end
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        bht_ridx = w_head_idx;
        bht_rsel = !lookup_active;
        // Decode lookup owns the port; wait as long as it needs.
        if (!lookup_active) begin
          w_we_nxt    = 1'b1;
          w_widx_nxt  = w_head_idx;
          w_wdata_nxt = sat2(bht_rdata, w_head_taken);
          w_pop       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_state_nxt = (r_count != '0) ? ST_READ : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (resolve_valid && !resolve_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= {resolve_taken, resolve_addr[IDX_W-1:0]};
    end
  end

endmodule
